// File: rtl/iobus_pkg.sv
// rtl/iobus_pkg.sv - shared constants for the I/O bus port bank
package iobus_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEF_OUT_BASE    = 32'h1100C000;
    localparam logic [WORD_W-1:0] DEF_IN_BASE     = 32'h11008000;
    localparam logic [WORD_W-1:0] DEF_STREAM_ADDR = 32'h1100C040;
    localparam logic [WORD_W-1:0] DEF_STATUS_ADDR = 32'h1100C044;
    localparam logic [WORD_W-1:0] DEF_MASK_ADDR   = 32'h1100C048;

    // Status word layout
    localparam int PEND_LSB  = 0;
    localparam int OVF_BIT   = 8;
    localparam int FULL_BIT  = 9;
    localparam int EMPTY_BIT = 10;
    localparam int COUNT_LSB = 16;

endpackage

// File: rtl/iobus_stream_fifo.sv
// rtl/iobus_stream_fifo.sv - first-word fall-through stream FIFO
//
// Ports: clk, rst_n (async active-low), push/push_data (write side),
// pop (consumer accept), head (oldest entry), full, empty, count.
module iobus_stream_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // still lands when the consumer is draining.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule

// File: rtl/iobus_port_bank.sv
// rtl/iobus_port_bank.sv - memory-mapped output/input/stream port bank
//
// Ports: clk, rst_n (async active-low); iobus_addr/iobus_out/iobus_wr
// (CPU store), iobus_in (combinational read data); out_regs_o/out_strobe_o
// (output registers and write pulses); in_ports_i (async inputs);
// stream_data_o/stream_valid_o/stream_ready_i (queued write stream);
// intr_o (registered masked change interrupt).
module iobus_port_bank
    import iobus_pkg::*;
#(
    parameter int                N_OUT       = 5,
    parameter int                N_IN        = 3,
    parameter logic [WORD_W-1:0] OUT_BASE    = DEF_OUT_BASE,
    parameter logic [WORD_W-1:0] IN_BASE     = DEF_IN_BASE,
    parameter logic [WORD_W-1:0] STREAM_ADDR = DEF_STREAM_ADDR,
    parameter logic [WORD_W-1:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [WORD_W-1:0] MASK_ADDR   = DEF_MASK_ADDR,
    parameter int                FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WORD_W-1:0]             iobus_addr,
    input  logic [WORD_W-1:0]             iobus_out,
    input  logic                          iobus_wr,
    output logic [WORD_W-1:0]             iobus_in,
    output logic [N_OUT-1:0][WORD_W-1:0]  out_regs_o,
    output logic [N_OUT-1:0]              out_strobe_o,
    input  logic [N_IN-1:0][WORD_W-1:0]   in_ports_i,
    output logic [WORD_W-1:0]             stream_data_o,
    output logic                          stream_valid_o,
    input  logic                          stream_ready_i,
    output logic                          intr_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [N_OUT-1:0][WORD_W-1:0] r_out;
    logic [N_OUT-1:0]             r_strobe;
    logic [N_IN-1:0][WORD_W-1:0]  r_sync1;
    logic [N_IN-1:0][WORD_W-1:0]  r_sync2;
    logic [N_IN-1:0][WORD_W-1:0]  r_prev;
    logic [N_IN-1:0]              r_pend;
    logic [N_IN-1:0]              r_mask;
    logic                         r_ovf;
    logic                         r_intr;

    logic [N_OUT-1:0]             w_out_hit;
    logic                         w_stream_wr;
    logic                         w_mask_wr;
    logic                         w_status_wr;
    logic [N_IN-1:0]              w_change;
    logic [N_IN-1:0]              w_pend_clr;
    logic                         w_ovf_set;
    logic                         w_ovf_clr;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_empty;
    logic [CW-1:0]                w_count;
    logic [WORD_W-1:0]            w_status;

    // Write decode
    always_comb begin
        for (int i = 0; i < N_OUT; i++) begin
            w_out_hit[i] = iobus_wr && (iobus_addr == OUT_BASE + 32'(4 * i));
        end
    end

    assign w_stream_wr = iobus_wr && (iobus_addr == STREAM_ADDR);
    assign w_mask_wr   = iobus_wr && (iobus_addr == MASK_ADDR);
    assign w_status_wr = iobus_wr && (iobus_addr == STATUS_ADDR);

    assign w_pend_clr = w_status_wr ? iobus_out[PEND_LSB +: N_IN] : '0;
    assign w_ovf_clr  = w_status_wr & iobus_out[OVF_BIT];
    assign w_pop      = stream_ready_i & ~w_empty;
    // A store to a full FIFO is lost unless the consumer frees a slot this cycle.
    assign w_ovf_set  = w_stream_wr & w_full & ~w_pop;

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_change[i] = (r_sync2[i] != r_prev[i]);
        end
    end

    // Output registers and their one-cycle write strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out    <= '0;
            r_strobe <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (w_out_hit[i]) r_out[i] <= iobus_out;
            end
            r_strobe <= w_out_hit;
        end
    end

    // Input synchronisers, change detect, pending/mask/interrupt, overflow.
    // A new change sets pending even when W1C hits the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_ovf   <= 1'b0;
            r_intr  <= 1'b0;
        end else begin
            r_sync1 <= in_ports_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_pend  <= (r_pend & ~w_pend_clr) | w_change;
            r_intr  <= |(r_pend & r_mask);
            if (w_mask_wr) r_mask <= iobus_out[N_IN-1:0];
            r_ovf   <= w_ovf_set | (r_ovf & ~w_ovf_clr);
        end
    end

    iobus_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_stream_wr),
        .push_data (iobus_out),
        .pop       (w_pop),
        .head      (stream_data_o),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_comb begin
        w_status                      = '0;
        w_status[PEND_LSB +: N_IN]    = r_pend;
        w_status[OVF_BIT]             = r_ovf;
        w_status[FULL_BIT]            = w_full;
        w_status[EMPTY_BIT]           = w_empty;
        w_status[COUNT_LSB +: CW]     = w_count;
    end

    // Read mux, independent of the write strobe
    always_comb begin
        iobus_in = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (iobus_addr == OUT_BASE + 32'(4 * i)) iobus_in = r_out[i];
        end
        for (int i = 0; i < N_IN; i++) begin
            if (iobus_addr == IN_BASE + 32'(4 * i)) iobus_in = r_sync2[i];
        end
        if (iobus_addr == STATUS_ADDR) iobus_in = w_status;
        if (iobus_addr == MASK_ADDR)   iobus_in[N_IN-1:0] = r_mask;
    end

    assign out_regs_o     = r_out;
    assign out_strobe_o   = r_strobe;
    assign stream_valid_o = ~w_empty;
    assign intr_o         = r_intr;

endmodule

// File: tb/tb_iobus_port_bank.sv
// tb/tb_iobus_port_bank.sv - randomized scoreboard bench for iobus_port_bank
module tb_iobus_port_bank;

    localparam int N_OUT = 5;
    localparam int N_IN  = 3;
    localparam int DEPTH = 8;
    localparam logic [31:0] OB  = 32'h1100C000;
    localparam logic [31:0] IB  = 32'h11008000;
    localparam logic [31:0] SA  = 32'h1100C040;
    localparam logic [31:0] STA = 32'h1100C044;
    localparam logic [31:0] MA  = 32'h1100C048;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [31:0]                iobus_addr = '0;
    logic [31:0]                iobus_out = '0;
    logic                       iobus_wr = 1'b0;
    logic [31:0]                iobus_in;
    logic [N_OUT-1:0][31:0]     out_regs_o;
    logic [N_OUT-1:0]           out_strobe_o;
    logic [N_IN-1:0][31:0]      in_ports_i = '0;
    logic [31:0]                stream_data_o;
    logic                       stream_valid_o;
    logic                       stream_ready_i = 1'b0;
    logic                       intr_o;

    iobus_port_bank dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iobus_addr     (iobus_addr),
        .iobus_out      (iobus_out),
        .iobus_wr       (iobus_wr),
        .iobus_in       (iobus_in),
        .out_regs_o     (out_regs_o),
        .out_strobe_o   (out_strobe_o),
        .in_ports_i     (in_ports_i),
        .stream_data_o  (stream_data_o),
        .stream_valid_o (stream_valid_o),
        .stream_ready_i (stream_ready_i),
        .intr_o         (intr_o)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct { int due; int idx; logic [31:0] val; } ev_t;
    logic [31:0]     m_out [N_OUT];
    logic [31:0]     m_in_vis [N_IN];
    logic [N_IN-1:0] m_pend, m_mask, pend_next_set;
    logic            m_ovf, m_intr;
    int              m_count;
    int              cyc;
    logic [31:0]     sb[$];
    ev_t             evq[$];
    logic [31:0]     alist [15];
    bit              mon_en = 0;
    int              n_checks = 0;
    int              n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < N_OUT; i++) if (a == OB + 32'(4 * i)) r = m_out[i];
        for (int i = 0; i < N_IN; i++)  if (a == IB + 32'(4 * i)) r = m_in_vis[i];
        if (a == STA) r = {8'h00, 8'(m_count), 5'b0, (m_count == 0), (m_count == DEPTH), m_ovf, 5'b0, m_pend};
        if (a == MA)  r = {29'b0, m_mask};
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_OUT; i++) m_out[i] = '0;
        for (int i = 0; i < N_IN; i++)  m_in_vis[i] = '0;
        m_pend = '0; m_mask = '0; pend_next_set = '0;
        m_ovf = 0; m_intr = 0; m_count = 0;
        sb.delete();
        evq.delete();
        // Inputs already nonzero look like a fresh change once reset releases.
        for (int i = 0; i < N_IN; i++)
            if (in_ports_i[i] != 0) evq.push_back('{cyc + 2, i, in_ports_i[i]});
    endtask

    task automatic set_in(input int i, input logic [31:0] v);
        in_ports_i[i] = v;
        evq.push_back('{cyc + 2, i, v});
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        iobus_wr = 0;
        iobus_addr = a;
        #1;
        v = iobus_in;
    endtask

    task automatic check_read(input logic [31:0] a);
        logic [31:0] v;
        rd(a, v);
        chk("read", v, m_read(a));
    endtask

    // One bus cycle: drive, predict, clock, then compare registered outputs.
    task automatic bus_cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic pop, push, acc, n_intr;
        logic [N_IN-1:0] clr, n_pend;
        int sidx;
        iobus_wr = w; iobus_addr = a; iobus_out = d;
        pop  = stream_ready_i && (m_count > 0);
        push = w && (a == SA);
        acc  = push && (m_count < DEPTH || pop);
        if (acc) sb.push_back(d);
        clr    = (w && a == STA) ? d[N_IN-1:0] : '0;
        n_pend = (m_pend & ~clr) | pend_next_set;
        n_intr = |(m_pend & m_mask);
        sidx = -1;
        for (int i = 0; i < N_OUT; i++) if (w && a == OB + 32'(4 * i)) sidx = i;
        @(posedge clk);
        #1;
        cyc++;
        iobus_wr = 0;
        m_count = m_count - int'(pop) + int'(acc);
        if (push && !acc) m_ovf = 1;
        else if (w && a == STA && d[8]) m_ovf = 0;
        if (sidx >= 0) m_out[sidx] = d;
        if (w && a == MA) m_mask = d[N_IN-1:0];
        m_pend = n_pend;
        m_intr = n_intr;
        pend_next_set = '0;
        while (evq.size() > 0 && evq[0].due == cyc) begin
            if (evq[0].val != m_in_vis[evq[0].idx]) pend_next_set[evq[0].idx] = 1'b1;
            m_in_vis[evq[0].idx] = evq[0].val;
            void'(evq.pop_front());
        end
        chk("strobe", {27'b0, out_strobe_o}, (sidx >= 0) ? (32'd1 << sidx) : 32'd0);
        for (int i = 0; i < N_OUT; i++) chk("out_reg", out_regs_o[i], m_out[i]);
        chk("intr", {31'b0, intr_o}, {31'b0, m_intr});
    endtask

    // Stream monitor: pops the scoreboard whenever the DUT hands over a word.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            chk("stream_valid", {31'b0, stream_valid_o}, {31'b0, (m_count != 0)});
            if (stream_valid_o && stream_ready_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stream_extra: got %h expected no word", stream_data_o);
                end else begin
                    chk("stream_data", stream_data_o, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int rdy_bias, op, k;
        logic [31:0] a, d;

        for (int i = 0; i < 6; i++) alist[i] = OB + 32'(4 * i);
        for (int i = 0; i < 4; i++) alist[6 + i] = IB + 32'(4 * i);
        alist[10] = SA; alist[11] = STA; alist[12] = MA; alist[13] = STA + 32'd8; alist[14] = 32'h0;

        cyc = 0;
        model_reset();

        // Reset state, reads while held in reset
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) check_read(alist[i]);
        chk("rst_valid", {31'b0, stream_valid_o}, 32'd0);
        chk("rst_intr", {31'b0, intr_o}, 32'd0);
        chk("rst_strobe", {27'b0, out_strobe_o}, 32'd0);
        rd(STA, v);
        chk("rst_status", v, 32'h0000_0400);
        @(posedge clk);
        #1;
        rst_n = 1;
        mon_en = 1;

        // Output register write and read-back
        bus_cycle(1, OB + 32'd8, 32'hDEADBEEF);
        chk("out2", out_regs_o[2], 32'hDEADBEEF);
        chk("out2_strobe", {27'b0, out_strobe_o}, 32'h4);
        rd(OB + 32'd8, v);
        chk("out2_read", v, 32'hDEADBEEF);
        bus_cycle(0, 0, 0);

        // Input latency and masked interrupt
        bus_cycle(1, MA, 32'h2);
        set_in(1, 32'd5);
        bus_cycle(0, 0, 0);
        bus_cycle(0, 0, 0);
        rd(IB + 32'd4, v);
        chk("in1_after2", v, 32'd5);
        rd(STA, v);
        chk("pend1_after2", {31'b0, v[1]}, 32'd0);
        bus_cycle(0, 0, 0);
        rd(STA, v);
        chk("pend1_after3", {31'b0, v[1]}, 32'd1);
        chk("intr_after3", {31'b0, intr_o}, 32'd0);
        bus_cycle(0, 0, 0);
        chk("intr_after4", {31'b0, intr_o}, 32'd1);
        bus_cycle(1, STA, 32'h2);
        chk("intr_w1c_1", {31'b0, intr_o}, 32'd1);
        bus_cycle(0, 0, 0);
        chk("intr_w1c_2", {31'b0, intr_o}, 32'd0);
        set_in(0, 32'd7);
        repeat (4) bus_cycle(0, 0, 0);
        rd(STA, v);
        chk("pend0_masked", {31'b0, v[0]}, 32'd1);
        chk("intr_masked", {31'b0, intr_o}, 32'd0);

        // W1C in the same cycle as a new pending set
        set_in(2, 32'd9);
        bus_cycle(0, 0, 0);
        bus_cycle(0, 0, 0);
        bus_cycle(1, STA, 32'h4);
        rd(STA, v);
        chk("pend2_set_wins", {31'b0, v[2]}, 32'd1);

        // Overflow with consumer stalled
        stream_ready_i = 0;
        for (int i = 1; i <= 9; i++) bus_cycle(1, SA, 32'h100 + 32'(i));
        rd(STA, v);
        chk("full_count", {24'b0, v[23:16]}, 32'd8);
        chk("full_bit", {31'b0, v[9]}, 32'd1);
        chk("ovf_bit", {31'b0, v[8]}, 32'd1);
        bus_cycle(1, STA, 32'h100);
        rd(STA, v);
        chk("ovf_cleared", {31'b0, v[8]}, 32'd0);
        // Push and pop together while full
        stream_ready_i = 1;
        bus_cycle(1, SA, 32'hAAAA_0009);
        rd(STA, v);
        chk("full_pushpop_count", {24'b0, v[23:16]}, 32'd8);
        chk("full_pushpop_ovf", {31'b0, v[8]}, 32'd0);
        for (int g = 0; g < 40 && m_count > 0; g++) bus_cycle(0, 0, 0);
        chk("drain1_sb", 32'(sb.size()), 32'd0);
        chk("drain1_valid", {31'b0, stream_valid_o}, 32'd0);

        // Randomized traffic
        rdy_bias = 2;
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) rdy_bias = $urandom_range(0, 3);
            stream_ready_i = ($urandom_range(0, 3) < rdy_bias);
            if ($urandom_range(0, 15) == 0) begin
                k = $urandom_range(0, N_IN - 1);
                set_in(k, in_ports_i[k] ^ (32'd1 << $urandom_range(0, 31)));
            end
            op = $urandom_range(0, 9);
            d  = $urandom;
            case (op)
                0, 1, 2: bus_cycle(1, OB + 32'(4 * $urandom_range(0, N_OUT)), d);
                3, 4, 5: bus_cycle(1, SA, d);
                6:       bus_cycle(1, MA, d);
                7:       bus_cycle(1, STA, d);
                8:       bus_cycle(1, IB + 32'(4 * $urandom_range(0, N_IN - 1)), d);
                default: bus_cycle(0, 0, 0);
            endcase
            a = alist[$urandom_range(0, 14)];
            check_read(a);
        end
        stream_ready_i = 1;
        for (int g = 0; g < 40 && m_count > 0; g++) bus_cycle(0, 0, 0);
        chk("drain2_sb", 32'(sb.size()), 32'd0);

        // Mid-run asynchronous reset with queued data and a live interrupt
        stream_ready_i = 0;
        for (int i = 0; i < 3; i++) bus_cycle(1, SA, $urandom);
        bus_cycle(1, OB, 32'h1234);
        bus_cycle(1, MA, 32'h7);
        set_in(0, in_ports_i[0] ^ 32'h1);
        repeat (4) bus_cycle(0, 0, 0);
        chk("pre_rst_intr", {31'b0, intr_o}, 32'd1);
        #1;
        rst_n = 0;
        #1;
        chk("arst_valid", {31'b0, stream_valid_o}, 32'd0);
        chk("arst_intr", {31'b0, intr_o}, 32'd0);
        chk("arst_strobe", {27'b0, out_strobe_o}, 32'd0);
        for (int i = 0; i < N_OUT; i++) chk("arst_out", out_regs_o[i], 32'd0);
        model_reset();
        rst_n = 1;
        repeat (5) bus_cycle(0, 0, 0);
        check_read(STA);
        for (int i = 0; i < N_IN; i++) check_read(IB + 32'(4 * i));
        stream_ready_i = 1;
        bus_cycle(1, SA, 32'h5555_0001);
        bus_cycle(1, SA, 32'h5555_0002);
        for (int g = 0; g < 20 && m_count > 0; g++) bus_cycle(0, 0, 0);
        chk("drain3_sb", 32'(sb.size()), 32'd0);

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
